// File: rtl/cc3000fpga_mss.sv
// cc3000fpga_mss: behavioural MSS stand-in bridging a UART byte-command link to an APB3 master, fabric GPIO and reset.
module cc3000fpga_mss #(
  parameter int CLKS_PER_BIT = 87,
  parameter int APB_TIMEOUT = 256
) (
  input  logic        SYSCLK,
  input  logic        SYSRESET,
  input  logic        MSSPREADY,
  input  logic        MSSPSLVERR,
  input  logic [31:0] MSSPRDATA,
  input  logic        FABINT,
  input  logic        F2M_GPI_31,
  input  logic        F2M_GPI_30,
  input  logic        F2M_GPI_8,
  input  logic        F2M_GPI_7,
  input  logic        F2M_GPI_6,
  input  logic        F2M_GPI_5,
  input  logic        GPIO_2_IN,
  input  logic        UART_0_RXD,
  input  logic        UART_1_RXD,
  output logic        FAB_CLK,
  output logic        M2F_RESET_N,
  output logic        MSSPSEL,
  output logic        MSSPENABLE,
  output logic        MSSPWRITE,
  output logic [19:0] MSSPADDR,
  output logic [31:0] MSSPWDATA,
  output logic        M2F_GPO_0,
  output logic        M2F_GPO_1,
  output logic        M2F_GPO_3,
  output logic        GPIO_4_OUT,
  output logic        UART_0_TXD,
  output logic        UART_1_TXD
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(APB_TIMEOUT + 1);
  localparam logic [7:0] C_W = 8'h57, C_R = 8'h52, C_G = 8'h47, C_I = 8'h49;
  localparam logic [7:0] R_OK = 8'h4B, R_ERR = 8'h45;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {S_IDLE, S_ARGS, S_APB_SETUP, S_APB_ACCESS, S_REPLY} st_t;
  logic          r_rst_n;
  logic [1:0]    r_u1;
  logic [1:0]    r_rx_s;
  logic          r_rx_d;
  rx_t           r_rx_st, w_rx_nxt;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_valid, r_rx_ferr;
  logic          r_tx_busy;
  logic [8:0]    r_tx_sh;
  logic [3:0]    r_tx_n;
  logic [CW-1:0] r_tx_cnt;
  st_t           r_st, w_nxt;
  logic [7:0]    r_cmd;
  logic [2:0]    r_nargs;
  logic [43:0]   r_args;
  logic [39:0]   r_rep;
  logic [2:0]    r_rep_n;
  logic [TW-1:0] r_tcnt;
  logic          r_psel, r_pen, r_pwrite;
  logic [19:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic [3:0]    r_gpo;
  logic          w_rx, w_rx_half, w_rx_tick, w_tx_tick;
  logic          w_last, w_tmo, w_tx_go, w_is_cmd, w_err;
  logic [51:0]   w_sh;
  logic [7:0]    w_gpi;
  assign FAB_CLK     = SYSCLK;
  assign M2F_RESET_N = r_rst_n;
  assign UART_1_TXD  = r_u1[1];
  assign UART_0_TXD  = r_tx_busy ? r_tx_sh[0] : 1'b1;
  assign MSSPSEL     = r_psel;
  assign MSSPENABLE  = r_pen;
  assign MSSPWRITE   = r_pwrite;
  assign MSSPADDR    = r_paddr;
  assign MSSPWDATA   = r_pwdata;
  assign {GPIO_4_OUT, M2F_GPO_3, M2F_GPO_1, M2F_GPO_0} = r_gpo;
  assign w_gpi = {F2M_GPI_31, F2M_GPI_30, F2M_GPI_8, F2M_GPI_7, F2M_GPI_6, F2M_GPI_5, GPIO_2_IN, FABINT};
  always_ff @(posedge SYSCLK) begin
    r_rst_n <= ~SYSRESET;
    r_u1    <= SYSRESET ? 2'b11 : {r_u1[0], UART_1_RXD};
  end
  assign w_rx      = r_rx_s[1];
  assign w_rx_half = r_rx_cnt == CW'(CLKS_PER_BIT / 2);
  assign w_rx_tick = r_rx_cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    w_rx_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE:  w_rx_nxt = (r_rx_d & ~w_rx) ? RX_START : RX_IDLE;
      RX_START: w_rx_nxt = !w_rx_half ? RX_START : w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  w_rx_nxt = (w_rx_tick && r_rx_bit == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  w_rx_nxt = w_rx_tick ? RX_IDLE : RX_STOP;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      r_rx_s     <= 2'b11;
      r_rx_d     <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s     <= {r_rx_s[0], UART_0_RXD};
      r_rx_d     <= w_rx;
      r_rx_st    <= w_rx_nxt;
      r_rx_cnt   <= (r_rx_st == RX_IDLE || r_rx_st != w_rx_nxt || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
      r_rx_bit   <= (r_rx_st != RX_DATA) ? 3'd0 : w_rx_tick ? r_rx_bit + 1'b1 : r_rx_bit;
      r_rx_sh    <= (r_rx_st == RX_DATA && w_rx_tick) ? {w_rx, r_rx_sh[7:1]} : r_rx_sh;
      r_rx_valid <= r_rx_st == RX_STOP && w_rx_tick && w_rx;
      r_rx_ferr  <= r_rx_st == RX_STOP && w_rx_tick && !w_rx;
    end
  end
  assign w_tx_tick = r_tx_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_tx_go   = r_st == S_REPLY && !r_tx_busy && r_rep_n != 3'd0;
  // Frame is {data, start}; ones shifted in from the top form the stop bit.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      r_tx_busy <= 1'b0;
      r_tx_sh   <= '1;
      r_tx_n    <= '0;
      r_tx_cnt  <= '0;
    end else if (w_tx_go) begin
      r_tx_busy <= 1'b1;
      r_tx_sh   <= {r_rep[39:32], 1'b0};
      r_tx_n    <= '0;
      r_tx_cnt  <= '0;
    end else if (r_tx_busy) begin
      r_tx_cnt  <= w_tx_tick ? '0 : r_tx_cnt + 1'b1;
      r_tx_sh   <= w_tx_tick ? {1'b1, r_tx_sh[8:1]} : r_tx_sh;
      r_tx_n    <= w_tx_tick ? r_tx_n + 1'b1 : r_tx_n;
      r_tx_busy <= !(w_tx_tick && r_tx_n == 4'd9);
    end
  end
  assign w_sh     = {r_args, r_rx_sh};
  assign w_last   = r_rx_valid && r_nargs == 3'd1;
  assign w_tmo    = r_tcnt == TW'(APB_TIMEOUT - 1);
  assign w_is_cmd = r_rx_sh == C_W || r_rx_sh == C_R || r_rx_sh == C_G;
  assign w_err    = !MSSPREADY || MSSPSLVERR;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:       w_nxt = !r_rx_valid ? S_IDLE : (r_rx_sh == C_I) ? S_REPLY : w_is_cmd ? S_ARGS : S_IDLE;
      S_ARGS:       w_nxt = r_rx_ferr ? S_IDLE : !w_last ? S_ARGS : (r_cmd == C_G) ? S_REPLY : S_APB_SETUP;
      S_APB_SETUP:  w_nxt = S_APB_ACCESS;
      S_APB_ACCESS: w_nxt = (MSSPREADY || w_tmo) ? S_REPLY : S_APB_ACCESS;
      S_REPLY:      w_nxt = (r_rep_n == 3'd0 && !r_tx_busy) ? S_IDLE : S_REPLY;
      default:      w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge SYSCLK) r_st <= SYSRESET ? S_IDLE : w_nxt;
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      r_cmd    <= '0;
      r_nargs  <= '0;
      r_args   <= '0;
      r_rep    <= '0;
      r_rep_n  <= '0;
      r_tcnt   <= '0;
      r_psel   <= 1'b0;
      r_pen    <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_gpo    <= '0;
    end else begin
      if (r_st == S_IDLE && r_rx_valid) begin
        r_cmd   <= r_rx_sh;
        r_nargs <= (r_rx_sh == C_W) ? 3'd7 : (r_rx_sh == C_R) ? 3'd3 : 3'd1;
        if (r_rx_sh == C_I) begin
          r_rep   <= {w_gpi, 32'h0};
          r_rep_n <= 3'd1;
        end
      end
      if (r_st == S_ARGS && r_rx_valid) begin
        r_args  <= w_sh[43:0];
        r_nargs <= r_nargs - 1'b1;
      end
      if (r_st == S_ARGS && w_last && r_cmd == C_G) begin
        r_gpo   <= r_rx_sh[3:0];
        r_rep   <= {R_OK, 32'h0};
        r_rep_n <= 3'd1;
      end
      if (r_st == S_ARGS && w_last && r_cmd != C_G) begin
        r_psel   <= 1'b1;
        r_pwrite <= r_cmd == C_W;
        r_paddr  <= (r_cmd == C_W) ? w_sh[51:32] : w_sh[19:0];
        r_pwdata <= (r_cmd == C_W) ? w_sh[31:0] : 32'h0;
      end
      if (r_st == S_APB_SETUP) begin
        r_pen  <= 1'b1;
        r_tcnt <= '0;
      end
      if (r_st == S_APB_ACCESS) begin
        r_tcnt <= r_tcnt + 1'b1;
        if (MSSPREADY || w_tmo) begin
          r_psel   <= 1'b0;
          r_pen    <= 1'b0;
          r_pwrite <= 1'b0;
          r_rep    <= {w_err ? R_ERR : R_OK, (w_err || r_pwrite) ? 32'h0 : MSSPRDATA};
          r_rep_n  <= r_pwrite ? 3'd1 : 3'd5;
        end
      end
      if (w_tx_go) begin
        r_rep   <= {r_rep[31:0], 8'h0};
        r_rep_n <= r_rep_n - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cc3000fpga_mss.sv
// tb_cc3000fpga_mss: directed checks of the UART command bridge, APB sequencing, GPIO, framing and loopback.
module tb_cc3000fpga_mss;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic fabint = 1'b0, g31 = 1'b0, g30 = 1'b0, g8 = 1'b0, g7 = 1'b0, g6 = 1'b0, g5 = 1'b0, gpio2 = 1'b0;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic fab_clk, m2f_rst_n, psel, penable, pwrite, gpo0, gpo1, gpo3, gpio4, txd0, txd1;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  int vecs = 0, errs = 0;
  int n_setup = 0, n_acc = 0, cur_acc = 0, rdy_after = 0;
  logic [19:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic s_write = 1'b0;
  logic [7:0] rq[$];
  cc3000fpga_mss #(.CLKS_PER_BIT(CPB), .APB_TIMEOUT(256)) dut (
    .SYSCLK(clk), .SYSRESET(rst), .MSSPREADY(pready), .MSSPSLVERR(pslverr), .MSSPRDATA(prdata),
    .FABINT(fabint), .F2M_GPI_31(g31), .F2M_GPI_30(g30), .F2M_GPI_8(g8), .F2M_GPI_7(g7),
    .F2M_GPI_6(g6), .F2M_GPI_5(g5), .GPIO_2_IN(gpio2), .UART_0_RXD(rxd0), .UART_1_RXD(rxd1),
    .FAB_CLK(fab_clk), .M2F_RESET_N(m2f_rst_n), .MSSPSEL(psel), .MSSPENABLE(penable),
    .MSSPWRITE(pwrite), .MSSPADDR(paddr), .MSSPWDATA(pwdata), .M2F_GPO_0(gpo0), .M2F_GPO_1(gpo1),
    .M2F_GPO_3(gpo3), .GPIO_4_OUT(gpio4), .UART_0_TXD(txd0), .UART_1_TXD(txd1)
  );
  always #5 clk = ~clk;
  // APB slave: raises ready during the rdy_after-th access cycle (0 = never)
  always @(negedge clk) begin
    if (psel && !penable) begin
      n_setup <= n_setup + 1;
      s_addr  <= paddr;
      s_wdata <= pwdata;
      s_write <= pwrite;
      cur_acc <= 0;
    end
    if (psel && penable) begin
      n_acc   <= n_acc + 1;
      cur_acc <= cur_acc + 1;
    end
    pready <= psel && penable && (cur_acc + 1 == rdy_after);
  end
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge txd0);
      repeat (CPB / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1;
        rb[i] = txd0;
      end
      repeat (CPB) @(posedge clk);
      #1;
      rq.push_back(rb);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd0 = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd0 = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd0 = stop;
    repeat (CPB) @(negedge clk);
    rxd0 = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
  endtask
  task automatic expect_reply(input string tag, input logic [39:0] v, input int n);
    logic [7:0] b;
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (rq.size() == 0 && t < 40 * CPB + 600) begin
        @(posedge clk);
        t++;
      end
      b = (rq.size() == 0) ? 8'hxx : rq.pop_front();
      chk(tag, {24'h0, b}, {24'h0, v[39-8*i -: 8]});
    end
  endtask
  initial begin
    int s0, a0;
    repeat (10) @(negedge clk);
    chk("rst_apb_ctl", {29'h0, psel, penable, pwrite}, 32'h0);
    chk("rst_addr", {12'h0, paddr}, 32'h0);
    chk("rst_wdata", pwdata, 32'h0);
    chk("rst_gpo", {28'h0, gpio4, gpo3, gpo1, gpo0}, 32'h0);
    chk("rst_txd", {30'h0, txd0, txd1}, 32'h3);
    chk("rst_m2f", {31'h0, m2f_rst_n}, 32'h0);
    chk("fab_clk_lo", {31'h0, fab_clk}, 32'h0);
    rst = 1'b0;
    #1 chk("m2f_before_edge", {31'h0, m2f_rst_n}, 32'h0);
    @(posedge clk);
    #1 chk("fab_clk_hi", {31'h0, fab_clk}, 32'h1);
    chk("m2f_after_edge", {31'h0, m2f_rst_n}, 32'h1);
    @(negedge clk);
    rxd1 = 1'b0;
    @(posedge clk);
    #1 chk("loop_lat1", {31'h0, txd1}, 32'h1);
    @(posedge clk);
    #1 chk("loop_lat2", {31'h0, txd1}, 32'h0);
    @(negedge clk);
    rxd1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("loop_back_hi", {31'h0, txd1}, 32'h1);
    s0 = n_setup; a0 = n_acc; rdy_after = 3;
    send(64'h57_00_12_34_DE_AD_BE_EF, 8);
    expect_reply("wr_reply", {8'h4B, 32'h0}, 1);
    chk("wr_setups", n_setup - s0, 1);
    chk("wr_access", n_acc - a0, 3);
    chk("wr_addr", {12'h0, s_addr}, 32'h01234);
    chk("wr_wdata", s_wdata, 32'hDEADBEEF);
    chk("wr_write", {31'h0, s_write}, 32'h1);
    chk("wr_idle_ctl", {29'h0, psel, penable, pwrite}, 32'h0);
    chk("wr_addr_hold", {12'h0, paddr}, 32'h01234);
    chk("wr_wdata_hold", pwdata, 32'hDEADBEEF);
    prdata = 32'hCAFEF00D; pslverr = 1'b1; rdy_after = 1;
    send(64'h52_0F_FF_FC, 4);
    expect_reply("rd_err_reply", {8'h45, 32'h0}, 5);
    chk("rd_addr", {12'h0, s_addr}, 32'hFFFFC);
    chk("rd_write", {31'h0, s_write}, 32'h0);
    chk("rd_wdata", s_wdata, 32'h0);
    pslverr = 1'b0;
    send(64'h52_0F_FF_FC, 4);
    expect_reply("rd_ok_reply", {8'h4B, 32'hCAFEF00D}, 5);
    a0 = n_acc; rdy_after = 0;
    send(64'h57_00_00_10_11_22_33_44, 8);
    expect_reply("tmo_reply", {8'h45, 32'h0}, 1);
    chk("tmo_access", n_acc - a0, 256);
    chk("tmo_idle_ctl", {29'h0, psel, penable, pwrite}, 32'h0);
    send(64'h47_0B, 2);
    expect_reply("gpo_reply", {8'h4B, 32'h0}, 1);
    chk("gpo_bits", {28'h0, gpio4, gpo3, gpo1, gpo0}, 32'hB);
    g31 = 1'b1; gpio2 = 1'b1;
    send(64'h49, 1);
    expect_reply("gpi_reply", {8'h82, 32'h0}, 1);
    g31 = 1'b0; gpio2 = 1'b0; g7 = 1'b1; fabint = 1'b1;
    send(64'h49, 1);
    expect_reply("gpi_reply2", {8'h11, 32'h0}, 1);
    s0 = n_setup;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    chk("ferr_no_apb", n_setup - s0, 0);
    chk("ferr_no_reply", rq.size(), 0);
    prdata = 32'h12345678; rdy_after = 1;
    send(64'h52_00_00_08, 4);
    expect_reply("ferr_next_reply", {8'h4B, 32'h12345678}, 5);
    chk("ferr_next_addr", {12'h0, s_addr}, 32'h00008);
    chk("ferr_next_setups", n_setup - s0, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_gpo", {28'h0, gpio4, gpo3, gpo1, gpo0}, 32'h0);
    chk("rst2_m2f", {31'h0, m2f_rst_n}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cc3000fpga_mss.md
Name: cc3000fpga_mss

Overview:
- Synthesizable behavioural stand-in for the microcontroller subsystem of the cc3000 FPGA design.
- UART_0 carries a byte-command host link that is bridged to an APB3 master port (MSSP*) into the fabric. The same link drives the fabric GPO lines and samples the GPI lines.
- UART_1 is a synchronized loopback.
- Provides the fabric clock and a fabric reset.

Parameters:
- CLKS_PER_BIT, 87, SYSCLK cycles per UART bit (10 MHz / 115200).
- APB_TIMEOUT, 256, max access-phase cycles waiting for MSSPREADY before forced error.

Ports:
- SYSCLK  in  1  system clock, 10 MHz.
- SYSRESET  in  1  synchronous active-high reset.
- MSSPREADY  in  1  APB ready.
- MSSPSLVERR  in  1  APB slave error.
- MSSPRDATA  in  32  APB read data.
- FABINT  in  1  fabric interrupt (status only).
- F2M_GPI_31, F2M_GPI_30, F2M_GPI_8, F2M_GPI_7, F2M_GPI_6, F2M_GPI_5  in  1 each  fabric inputs.
- GPIO_2_IN  in  1  pad input.
- UART_0_RXD, UART_1_RXD  in  1 each  serial in, idle high.
- FAB_CLK  out  1  fabric clock.
- M2F_RESET_N  out  1  fabric reset, active low.
- MSSPSEL, MSSPENABLE, MSSPWRITE  out  1 each  APB control.
- MSSPADDR  out  20  APB address.
- MSSPWDATA  out  32  APB write data.
- M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, GPIO_4_OUT  out  1 each  GPO bits.
- UART_0_TXD, UART_1_TXD  out  1 each  serial out.

Behaviour:
- Reset values: all APB outputs 0; all GPOs 0; both TXDs 1; M2F_RESET_N 0. M2F_RESET_N is a register = ~SYSRESET, so it goes to 1 on the first edge after reset release.
- FAB_CLK = SYSCLK (combinational pass-through).
- UART_1_TXD = UART_1_RXD through 2 flops (2-cycle latency).
- UART_0, 8N1, LSB first:
  - RXD is 2-flop synchronized.
  - Start is detected on a falling edge and confirmed at mid-bit (CLKS_PER_BIT/2); a high sample there returns RX to idle.
  - Data and stop bits are sampled every CLKS_PER_BIT.
  - Stop bit 0 = framing error: the byte is discarded and the command parser returns to IDLE.
  - TX sends start, 8 data bits, stop; each bit lasts CLKS_PER_BIT cycles.
  - TX bytes queue in the command FSM; there is no overlap. The next RX byte is not processed until the reply has been fully sent.
- Command FSM (IDLE, ARGS, APB_SETUP, APB_ACCESS, REPLY). Multi-byte fields are MSB first.
  - 0x57 'W' + 3 addr bytes + 4 data bytes: APB write. addr[23:20] is ignored.
  - 0x52 'R' + 3 addr bytes: APB read.
  - 0x47 'G' + 1 byte b: M2F_GPO_0=b[0], M2F_GPO_1=b[1], M2F_GPO_3=b[2], GPIO_4_OUT=b[3]. Outputs update the cycle after the byte completes. Reply 0x4B.
  - 0x49 'I': reply one byte {F2M_GPI_31, F2M_GPI_30, F2M_GPI_8, F2M_GPI_7, F2M_GPI_6, F2M_GPI_5, GPIO_2_IN, FABINT}. Bit 7 is first in this list. Inputs are sampled when the command byte completes.
  - Any other byte in IDLE is ignored.
- APB sequence:
  - SETUP: one cycle with PSEL=1, PENABLE=0, ADDR/WRITE/WDATA valid (WDATA 0 for reads).
  - ACCESS: PSEL=1, PENABLE=1, held until MSSPREADY=1 is sampled.
  - Next cycle: PSEL, PENABLE and WRITE return to 0; ADDR and WDATA hold their last values.
  - Read data and SLVERR are captured on the ready cycle.
  - If APB_TIMEOUT access cycles elapse without ready, the transfer ends with error status and the bus is idled.
- Replies:
  - Write: 0x4B 'K' on success, 0x45 'E' on SLVERR or timeout.
  - Read: status byte, then 4 data bytes MSB first on success. On error, 0x45 followed by 0x00 ×4.
- SYSRESET mid-operation aborts any APB transfer, UART frame or command immediately and restores reset values. GPO state is lost.

Test Plan:
- Reset: hold SYSRESET 10 cycles -> all APB/GPO outputs 0, TXDs 1, M2F_RESET_N 0; then 1 one cycle after release. FAB_CLK tracks SYSCLK.
- Write: send 57 00 12 34 DE AD BE EF, slave readies on 3rd access cycle -> one setup cycle with ADDR=0x01234, WDATA=0xDEADBEEF, WRITE=1; 3 access cycles; reply 0x4B.
- Read with error: send 52 0F FF FC, PRDATA=0xCAFEF00D, SLVERR=1 at ready -> reply 45 00 00 00 00. Same with SLVERR=0 -> reply 4B CA FE F0 0D.
- Timeout: MSSPREADY tied 0, send write -> PENABLE high exactly 256 cycles, then bus idle, reply 0x45.
- GPIO: send 47 0B -> M2F_GPO_0=1, M2F_GPO_1=1, M2F_GPO_3=0, GPIO_4_OUT=1, reply 4B. Set F2M_GPI_31=1, GPIO_2_IN=1, others 0, send 49 -> reply 0x82.
- Framing/loopback: byte with stop bit 0 mid 'W' command -> no APB activity, next valid command works. Toggle UART_1_RXD -> UART_1_TXD follows 2 cycles later.
